// File: rtl/cim_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cim_seq_pkg
//  Purpose  : Shared types and constants for the CIM inference sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package cim_seq_pkg;

    // Cycles from EN to REQ on the macro inference port
    localparam int MACRO_LAT    = 4;

    localparam int DEF_N_IN     = 256;
    localparam int DEF_N_NEURON = 16;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_TIMEOUT  = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } seq_state_t;

    // Index width for a neuron number; never zero
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cim_spike_counter.sv
`default_nettype none
// ============================================================================
//  Module   : cim_spike_counter
//  Purpose  : Bank of per-neuron saturating spike counters with a sample
//             clear. When CIM_ARGMAX_EN is defined it also produces the index
//             of the largest next-state count (lowest index wins ties).
//  Revision : 1.0  initial release
// ============================================================================
module cim_spike_counter
    import cim_seq_pkg::*;
#(
    parameter int N_NEURON = DEF_N_NEURON,
    parameter int CNT_W    = DEF_CNT_W
`ifdef CIM_ARGMAX_EN
    ,
    parameter int IDX_W    = idx_width(N_NEURON)
`endif
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      i_clr,
    input  logic                      i_inc_en,
    input  logic [N_NEURON-1:0]       i_inc,
    output logic [N_NEURON*CNT_W-1:0] o_cnt
`ifdef CIM_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]          o_argmax_nxt
`endif
);

    // Next-state counts, flattened the same way as o_cnt
    logic [N_NEURON*CNT_W-1:0] w_nxt;

    for (genvar gi = 0; gi < N_NEURON; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             w_sat;

        assign w_sat = &r_cnt;
        assign w_nxt[gi*CNT_W +: CNT_W] =
            i_clr ? '0 :
            ((i_inc_en && i_inc[gi] && !w_sat) ? r_cnt + CNT_W'(1) : r_cnt);

        // Counter register follows the clear/increment/saturate decision
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) r_cnt <= '0;
            else     r_cnt <= w_nxt[gi*CNT_W +: CNT_W];
        end

        assign o_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end

`ifdef CIM_ARGMAX_EN
    logic [IDX_W-1:0] w_best_idx;
    logic [CNT_W-1:0] w_best_val;

    // Argmax over next-state counts so the final REQ's fires are included;
    // strict compare keeps the lowest index on ties
    always_comb begin
        w_best_idx = '0;
        w_best_val = w_nxt[CNT_W-1:0];
        for (int i = 1; i < N_NEURON; i++) begin
            if (w_nxt[i*CNT_W +: CNT_W] > w_best_val) begin
                w_best_val = w_nxt[i*CNT_W +: CNT_W];
                w_best_idx = IDX_W'(i);
            end
        end
    end

    assign o_argmax_nxt = w_best_idx;
`endif

endmodule
`default_nettype wire

// File: rtl/cim_infer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cim_infer_seq
//  Purpose  : Inference sequencer for a CIM macro. Takes one spike vector per
//             timestep, pulses EN (FT on a sample's first timestep), waits for
//             REQ, accumulates NEURON_OUT into saturating counters and hands
//             the per-sample counts downstream.
//  Options  : CIM_ARGMAX_EN adds OUT_CLASS (index of the largest count).
//  Revision : 1.0  initial release
// ============================================================================
module cim_infer_seq
    import cim_seq_pkg::*;
#(
    parameter int N_IN     = DEF_N_IN,
    parameter int N_NEURON = DEF_N_NEURON,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
`ifdef CIM_ARGMAX_EN
    ,
    parameter int IDX_W    = idx_width(N_NEURON)
`endif
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic                      RSTB,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [N_IN-1:0]           IN_SPIKE,
    input  logic                      IN_LAST,
    output logic                      EN,
    output logic                      FT,
    output logic [N_IN-1:0]           SPIKE_REMAP,
    input  logic                      REQ,
    input  logic [N_NEURON-1:0]       NEURON_OUT,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [N_NEURON*CNT_W-1:0] OUT_COUNT,
    output logic                      ERR,
    input  logic                      ERR_CLR
`ifdef CIM_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]          OUT_CLASS
`endif
);

    // A limit at or below the macro latency would abort every healthy reply
    localparam int TMO_LIM = (TIMEOUT > MACRO_LAT) ? TIMEOUT : MACRO_LAT + 1;
    localparam int TMO_W   = $clog2(TMO_LIM + 1);

    seq_state_t        r_state;
    logic              r_first;
    logic              r_last;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_in_ready;
    logic              r_en;
    logic              r_ft;
    logic [N_IN-1:0]   r_spike;
    logic              r_out_valid;
    logic              r_err;

    logic              w_accept;
    logic              w_req_hit;
    logic              w_timeout;

    assign w_accept  = (r_state == ST_IDLE) && IN_VALID && r_in_ready;
    assign w_req_hit = (r_state == ST_WAIT) && REQ;
    // r_tmo counts cycles since EN; abort when the next count reaches the limit
    assign w_timeout = (r_state == ST_WAIT) && !REQ && ((int'(r_tmo) + 1) >= TMO_LIM);

`ifdef CIM_ARGMAX_EN
    logic [IDX_W-1:0]  w_argmax_nxt;
    logic [IDX_W-1:0]  r_class;
`endif

    cim_spike_counter #(
        .N_NEURON (N_NEURON),
        .CNT_W    (CNT_W)
    ) u_cnt (
        .CLK          (CLK),
        .RST          (RST),
        .i_clr        (w_accept && r_first),
        .i_inc_en     (w_req_hit),
        .i_inc        (NEURON_OUT),
        .o_cnt        (OUT_COUNT)
`ifdef CIM_ARGMAX_EN
        ,
        .o_argmax_nxt (w_argmax_nxt)
`endif
    );

    // Sequencer FSM with registered handshake, macro and error outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_first     <= 1'b1;
            r_last      <= 1'b0;
            r_tmo       <= '0;
            r_in_ready  <= 1'b0;
            r_en        <= 1'b0;
            r_ft        <= 1'b0;
            r_spike     <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
`ifdef CIM_ARGMAX_EN
            r_class     <= '0;
`endif
        end else begin
            r_en <= 1'b0;
            r_ft <= 1'b0;

            if (w_timeout)    r_err <= 1'b1;
            else if (ERR_CLR) r_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_spike    <= IN_SPIKE;
                        r_last     <= IN_LAST;
                        r_in_ready <= 1'b0;
                        r_en       <= 1'b1;
                        r_ft       <= r_first;
                        r_state    <= ST_ISSUE;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_first <= 1'b0;
                    r_tmo   <= TMO_W'(1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (REQ) begin
                        if (r_last) begin
                            r_first     <= 1'b1;
                            r_out_valid <= 1'b1;
`ifdef CIM_ARGMAX_EN
                            r_class     <= w_argmax_nxt;
`endif
                            r_state     <= ST_OUT;
                        end else begin
                            r_in_ready  <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_first    <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_OUT: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign RSTB        = ~RST;
    assign IN_READY    = r_in_ready;
    assign EN          = r_en;
    assign FT          = r_ft;
    assign SPIKE_REMAP = r_spike;
    assign OUT_VALID   = r_out_valid;
    assign ERR         = r_err;
`ifdef CIM_ARGMAX_EN
    assign OUT_CLASS   = r_class;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cim_infer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cim_infer_seq
//  Purpose  : Directed self-checking bench for cim_infer_seq with a
//             bus-functional macro model (REQ four cycles after EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cim_infer_seq;

    localparam int N_IN     = 256;
    localparam int N_NEURON = 16;
    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 15;

    logic                      CLK = 1'b0;
    logic                      RST;
    logic                      RSTB;
    logic                      IN_VALID;
    logic                      IN_READY;
    logic [N_IN-1:0]           IN_SPIKE;
    logic                      IN_LAST;
    logic                      EN;
    logic                      FT;
    logic [N_IN-1:0]           SPIKE_REMAP;
    logic                      REQ;
    logic [N_NEURON-1:0]       NEURON_OUT;
    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [N_NEURON*CNT_W-1:0] OUT_COUNT;
    logic                      ERR;
    logic                      ERR_CLR;
`ifdef CIM_ARGMAX_EN
    logic [3:0]                OUT_CLASS;
`endif

    cim_infer_seq #(
        .N_IN     (N_IN),
        .N_NEURON (N_NEURON),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RSTB        (RSTB),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_SPIKE    (IN_SPIKE),
        .IN_LAST     (IN_LAST),
        .EN          (EN),
        .FT          (FT),
        .SPIKE_REMAP (SPIKE_REMAP),
        .REQ         (REQ),
        .NEURON_OUT  (NEURON_OUT),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_COUNT   (OUT_COUNT),
        .ERR         (ERR),
        .ERR_CLR     (ERR_CLR)
`ifdef CIM_ARGMAX_EN
        ,
        .OUT_CLASS   (OUT_CLASS)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus-functional macro ----------------
    logic [3:0]  en_hist   = '0;
    logic        bfm_req   = 1'b0;
    logic [15:0] bfm_fire  = '0;
    logic        rogue_req = 1'b0;
    bit          mute      = 1'b0;
    logic [15:0] fireq[$];
    int          en_cnt = 0, ft_cnt = 0, en_cyc = 0, prev_en_cyc = -100, viol = 0;
    bit          last_ft = 1'b0;

    assign REQ        = bfm_req | rogue_req;
    assign NEURON_OUT = bfm_req ? bfm_fire : (rogue_req ? 16'hFFFF : 16'h0000);

    always @(negedge CLK) begin
        if (RST) begin
            en_hist     = '0;
            bfm_req     = 1'b0;
            prev_en_cyc = -100;
            fireq.delete();
        end else begin
            bfm_req  = en_hist[3] && !mute;
            bfm_fire = '0;
            if (bfm_req && fireq.size() > 0) bfm_fire = fireq.pop_front();
            en_hist = {en_hist[2:0], EN};
            if (EN) begin
                en_cnt++;
                if (cyc - prev_en_cyc < 6) viol++;
                prev_en_cyc = cyc;
                en_cyc      = cyc;
                last_ft     = FT;
                if (FT) ft_cnt++;
            end
            if (FT && !EN) viol++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_vec(input logic [N_IN-1:0] sp, input bit last, input logic [15:0] fire);
        int n;
        if (!mute) fireq.push_back(fire);
        @(negedge CLK);
        IN_VALID = 1'b1;
        IN_SPIKE = sp;
        IN_LAST  = last;
        n = 0;
        while (!IN_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("accept", IN_READY, 1);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_out(output int oc);
        int n;
        n = 0;
        @(negedge CLK);
        while (!OUT_VALID && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("out_valid", OUT_VALID, 1);
        oc = cyc;
    endtask

    task automatic ack_out();
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("out_valid_drop", OUT_VALID, 0);
        chk("in_ready_back", IN_READY, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit hit after %0d compares", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_IN-1:0] sp;
        int oc, en0, ft0;
        RST = 1'b1; IN_VALID = 1'b0; IN_SPIKE = '0; IN_LAST = 1'b0;
        OUT_READY = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(negedge CLK);

        // reset values
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_en", EN, 0);
        chk("rst_ft", FT, 0);
        chk("rst_remap", SPIKE_REMAP, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_count", OUT_COUNT, 0);
        chk("rst_err", ERR, 0);
        chk("rst_rstb", RSTB, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_ready", IN_READY, 1);

        // single-timestep sample
        sp = {8{32'hA5A5_0001}};
        en0 = en_cnt;
        send_vec(sp, 1'b1, 16'h0005);
        chk("remap_load", SPIKE_REMAP, sp);
        wait_out(oc);
        chk("t1_count", OUT_COUNT, 128'h0001_0001);
        chk("t1_latency", oc - en_cyc, 5);
        chk("t1_ft", last_ft, 1);
        chk("t1_en_cnt", en_cnt - en0, 1);
        chk("t1_remap_hold", SPIKE_REMAP, sp);
        ack_out();

        // three timesteps with an upstream stall and a stray REQ in IDLE
        en0 = en_cnt; ft0 = ft_cnt;
        send_vec({N_IN{1'b1}}, 1'b0, 16'h0001);
        repeat (7) @(negedge CLK);
        rogue_req = 1'b1;
        @(negedge CLK);
        rogue_req = 1'b0;
        send_vec({128'h0, {128{1'b1}}}, 1'b0, 16'h0003);
        send_vec({N_IN{1'b0}}, 1'b1, 16'h0001);
        wait_out(oc);
        chk("t2_count", OUT_COUNT, 128'h0103);
        chk("t2_en_cnt", en_cnt - en0, 3);
        chk("t2_ft_cnt", ft_cnt - ft0, 1);
        chk("t2_last_ft", last_ft, 0);
        ack_out();

        // saturation: neuron3 fires on 257 timesteps
        for (int i = 0; i < 257; i++) send_vec(sp, (i == 256), 16'h0008);
        wait_out(oc);
        chk("sat_count", OUT_COUNT, 128'hFF00_0000);
        ack_out();

        // timeout: macro never answers
        mute = 1'b1;
        send_vec(sp, 1'b1, 16'h0000);
        begin
            int n;
            n = 0;
            while (!ERR && n < 50) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("to_err", ERR, 1);
        chk("to_latency", cyc - en_cyc, TIMEOUT);
        chk("to_no_out", OUT_VALID, 0);
        chk("to_ready", IN_READY, 1);
        mute = 1'b0;
        send_vec(sp, 1'b1, 16'h0002);
        wait_out(oc);
        chk("to_next_ft", last_ft, 1);
        chk("to_next_count", OUT_COUNT, 128'h0100);
        chk("err_sticky", ERR, 1);
        ack_out();
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("err_clr", ERR, 0);

        // downstream backpressure with a stray REQ during OUT
        send_vec(sp, 1'b1, 16'h8000);
        wait_out(oc);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("bp_valid", OUT_VALID, 1);
            chk("bp_count", OUT_COUNT, {8'h01, 120'h0});
            chk("bp_in_ready", IN_READY, 0);
            rogue_req = (i == 3);
        end
        rogue_req = 1'b0;
        ack_out();

        // reset during WAIT of timestep 2
        send_vec(sp, 1'b0, 16'h0001);
        send_vec(sp, 1'b0, 16'h0001);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_rst_in_ready", IN_READY, 0);
        chk("mid_rst_en", EN, 0);
        chk("mid_rst_remap", SPIKE_REMAP, 0);
        chk("mid_rst_out_valid", OUT_VALID, 0);
        chk("mid_rst_count", OUT_COUNT, 0);
        chk("mid_rst_err", ERR, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        send_vec(sp, 1'b1, 16'h0010);
        wait_out(oc);
        chk("post_rst_ft", last_ft, 1);
        chk("post_rst_count", OUT_COUNT, 128'h01_0000_0000);
        ack_out();

`ifdef CIM_ARGMAX_EN
        // tie between neuron5 and neuron9 resolves to 5
        send_vec(sp, 1'b0, 16'h0221);
        send_vec(sp, 1'b0, 16'h0220);
        send_vec(sp, 1'b0, 16'h0220);
        send_vec(sp, 1'b1, 16'h0220);
        wait_out(oc);
        chk("am_count", OUT_COUNT, (128'h4 << 72) | (128'h4 << 40) | 128'h1);
        chk("am_class_tie", OUT_CLASS, 5);
        ack_out();
        send_vec(sp, 1'b1, 16'h1000);
        wait_out(oc);
        chk("am_class_single", OUT_CLASS, 12);
        ack_out();
`endif

        chk("en_spacing_ft", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
